// File: rtl/field_merge_pkg.sv
// ----------------------------------------------------------------------------
// field_merge_pkg
// Shared definitions for the field merge scheduler slice.
//
// Contents:
//   - default widths for data, record index, byte strobes and statistics
//   - one-hot scheduler state encoding (SCAN / HOLD / ADV)
//   - source tags for the output stream (SRC_VARINT / SRC_RAW)
// ----------------------------------------------------------------------------
package field_merge_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int IDX_W_DEF  = 10;
    localparam int STRB_W_DEF = 4;
    localparam int STAT_W_DEF = 32;

    // One-hot so each state decodes from a single flop.
    typedef enum logic [2:0] {
        SCAN = 3'b001,
        HOLD = 3'b010,
        ADV  = 3'b100
    } sched_state_e;

    localparam logic SRC_VARINT = 1'b0;
    localparam logic SRC_RAW    = 1'b1;

endpackage

// File: rtl/sched_stat_cnt.sv
// ----------------------------------------------------------------------------
// sched_stat_cnt
// Saturating event counter used by the scheduler statistics.
//
// Ports:
//   clk    - clock
//   reset  - synchronous active-low reset
//   clr    - synchronous clear, has priority over inc
//   inc    - count one event this cycle
//   count  - current count, sticks at all-ones
// ----------------------------------------------------------------------------
module sched_stat_cnt #(
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [STAT_W-1:0] count
);

    logic [STAT_W-1:0] count_q;
    logic [STAT_W-1:0] count_d;

    // Next count: clear first, otherwise step unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {STAT_W{1'b1}})) begin
            count_d = count_q + STAT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/field_merge_sched.sv
// ----------------------------------------------------------------------------
// field_merge_sched
// Drains the varint and raw-data FIFOs into one encoder stream. Words are
// emitted in record-index order; inside one record all varint words leave
// before any raw-data word. The head of each FIFO is show-ahead, so a word
// is popped in the same cycle it is captured into the output registers.
//
// Ports:
//   clk, reset          - clock, synchronous active-low reset
//   sched_clr           - synchronous clear (issued with the FIFO clears)
//   eos                 - end of stream: an empty FIFO holds no more words
//                         for the record being drained
//   varint_*            - varint FIFO read side (empty, head, pop)
//   raw_*               - raw FIFO read side (empty, head, strobes, pop)
//   m_valid/m_ready     - output handshake
//   m_data/m_wstrb      - output word and strobes (all-ones for varint)
//   m_index/m_src       - record index and source (0 varint, 1 raw)
//   m_rec_end           - one-cycle pulse when exp_index advances
//   exp_index           - record index currently being drained
//
// Optional build macro FIELD_MERGE_SCHED_STATS_EN adds the saturating
// statistics outputs stat_varint_words, stat_raw_words and stat_records.
// ----------------------------------------------------------------------------
module field_merge_sched
    import field_merge_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int STRB_W = STRB_W_DEF
`ifdef FIELD_MERGE_SCHED_STATS_EN
    ,
    parameter int STAT_W = STAT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sched_clr,
    input  logic              eos,

    input  logic              varint_empty,
    input  logic [DATA_W-1:0] varint_head_data,
    input  logic [IDX_W-1:0]  varint_head_index,
    output logic              varint_pop,

    input  logic              raw_empty,
    input  logic [DATA_W-1:0] raw_head_data,
    input  logic [IDX_W-1:0]  raw_head_index,
    input  logic [STRB_W-1:0] raw_head_wstrb,
    output logic              raw_pop,

    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [STRB_W-1:0] m_wstrb,
    output logic [IDX_W-1:0]  m_index,
    output logic              m_src,
    output logic              m_rec_end,
    output logic [IDX_W-1:0]  exp_index
`ifdef FIELD_MERGE_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_varint_words,
    output logic [STAT_W-1:0] stat_raw_words,
    output logic [STAT_W-1:0] stat_records
`endif
);

    sched_state_e      state_q,     state_d;
    logic [IDX_W-1:0]  exp_index_q, exp_index_d;
    logic              m_valid_q,   m_valid_d;
    logic [DATA_W-1:0] m_data_q,    m_data_d;
    logic [STRB_W-1:0] m_wstrb_q,   m_wstrb_d;
    logic [IDX_W-1:0]  m_index_q,   m_index_d;
    logic              m_src_q,     m_src_d;
    logic              m_rec_end_q, m_rec_end_d;

    logic              varint_take;
    logic              raw_take;
    logic              vm;
    logic              rm;

    // A head "matches" only when it is present and tagged with exactly the
    // record being drained; there is deliberately no ordering comparison.
    assign vm = !varint_empty && (varint_head_index == exp_index_q);
    assign rm = !raw_empty    && (raw_head_index    == exp_index_q);

    // Next-state logic. SCAN picks the next word (varint first) or decides
    // the current record is finished; a record is only declared finished
    // when some FIFO actually shows a later word, so two empty FIFOs never
    // let exp_index run away even with eos high.
    always_comb begin
        state_d     = state_q;
        exp_index_d = exp_index_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_wstrb_d   = m_wstrb_q;
        m_index_d   = m_index_q;
        m_src_d     = m_src_q;
        m_rec_end_d = 1'b0;
        varint_take = 1'b0;
        raw_take    = 1'b0;

        if (sched_clr) begin
            state_d     = SCAN;
            exp_index_d = '0;
            m_valid_d   = 1'b0;
            m_data_d    = '0;
            m_wstrb_d   = '0;
            m_index_d   = '0;
            m_src_d     = SRC_VARINT;
        end else begin
            case (state_q)
                SCAN: begin
                    if (vm) begin
                        varint_take = 1'b1;
                        m_valid_d   = 1'b1;
                        m_data_d    = varint_head_data;
                        m_wstrb_d   = {STRB_W{1'b1}};
                        m_index_d   = varint_head_index;
                        m_src_d     = SRC_VARINT;
                        state_d     = HOLD;
                    end else if (rm) begin
                        raw_take    = 1'b1;
                        m_valid_d   = 1'b1;
                        m_data_d    = raw_head_data;
                        m_wstrb_d   = raw_head_wstrb;
                        m_index_d   = raw_head_index;
                        m_src_d     = SRC_RAW;
                        state_d     = HOLD;
                    end else if (!varint_empty && !raw_empty) begin
                        state_d = ADV;
                    end else if (eos && (!varint_empty || !raw_empty)) begin
                        state_d = ADV;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid_d = 1'b0;
                        state_d   = SCAN;
                    end
                end
                ADV: begin
                    exp_index_d = exp_index_q + IDX_W'(1);
                    m_rec_end_d = 1'b1;
                    state_d     = SCAN;
                end
                default: begin
                    state_d   = SCAN;
                    m_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Pops go out combinationally in the capture cycle; reset gates them
    // here because the register reset alone would not stop this cycle's pop.
    assign varint_pop = varint_take && reset;
    assign raw_pop    = raw_take    && reset;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= SCAN;
            exp_index_q <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_wstrb_q   <= '0;
            m_index_q   <= '0;
            m_src_q     <= SRC_VARINT;
            m_rec_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_index_q <= exp_index_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_wstrb_q   <= m_wstrb_d;
            m_index_q   <= m_index_d;
            m_src_q     <= m_src_d;
            m_rec_end_q <= m_rec_end_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_wstrb   = m_wstrb_q;
    assign m_index   = m_index_q;
    assign m_src     = m_src_q;
    assign m_rec_end = m_rec_end_q;
    assign exp_index = exp_index_q;

`ifdef FIELD_MERGE_SCHED_STATS_EN
    logic varint_accept;
    logic raw_accept;
    logic rec_advance;

    // A transfer is counted when the held word is accepted; a clear in the
    // same cycle wins and the counters are zeroed instead.
    assign varint_accept = (state_q == HOLD) && m_ready && (m_src_q == SRC_VARINT);
    assign raw_accept    = (state_q == HOLD) && m_ready && (m_src_q == SRC_RAW);
    assign rec_advance   = (state_q == ADV);

    sched_stat_cnt #(.STAT_W(STAT_W)) u_cnt_varint (
        .clk   (clk),
        .reset (reset),
        .clr   (sched_clr),
        .inc   (varint_accept),
        .count (stat_varint_words)
    );

    sched_stat_cnt #(.STAT_W(STAT_W)) u_cnt_raw (
        .clk   (clk),
        .reset (reset),
        .clr   (sched_clr),
        .inc   (raw_accept),
        .count (stat_raw_words)
    );

    sched_stat_cnt #(.STAT_W(STAT_W)) u_cnt_records (
        .clk   (clk),
        .reset (reset),
        .clr   (sched_clr),
        .inc   (rec_advance),
        .count (stat_records)
    );
`endif

endmodule

// File: tb/tb_field_merge_sched.sv
// ----------------------------------------------------------------------------
// tb_field_merge_sched
// Bench for field_merge_sched: two queue-backed show-ahead FIFO models feed
// the scheduler, every accepted output word is logged, and the log is
// compared against the expected record-ordered stream.
// ----------------------------------------------------------------------------
module tb_field_merge_sched;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 10;
    localparam int STRB_W = 4;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } word_t;

    typedef struct packed {
        logic              src;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } obs_t;

    logic              clk;
    logic              reset;
    logic              sched_clr;
    logic              eos;
    logic              varint_empty;
    logic [DATA_W-1:0] varint_head_data;
    logic [IDX_W-1:0]  varint_head_index;
    logic              varint_pop;
    logic              raw_empty;
    logic [DATA_W-1:0] raw_head_data;
    logic [IDX_W-1:0]  raw_head_index;
    logic [STRB_W-1:0] raw_head_wstrb;
    logic              raw_pop;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [STRB_W-1:0] m_wstrb;
    logic [IDX_W-1:0]  m_index;
    logic              m_src;
    logic              m_rec_end;
    logic [IDX_W-1:0]  exp_index;

    word_t vq[$];
    word_t rq[$];
    obs_t  obsQ[$];
    obs_t  expQ[$];

    int passCount    = 0;
    int totalCount   = 0;
    int popCount     = 0;
    int recEndCount  = 0;
    int xferCount    = 0;
    int recEndBadIdx = 0;

    field_merge_sched #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .STRB_W (STRB_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .sched_clr         (sched_clr),
        .eos               (eos),
        .varint_empty      (varint_empty),
        .varint_head_data  (varint_head_data),
        .varint_head_index (varint_head_index),
        .varint_pop        (varint_pop),
        .raw_empty         (raw_empty),
        .raw_head_data     (raw_head_data),
        .raw_head_index    (raw_head_index),
        .raw_head_wstrb    (raw_head_wstrb),
        .raw_pop           (raw_pop),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_data            (m_data),
        .m_wstrb           (m_wstrb),
        .m_index           (m_index),
        .m_src             (m_src),
        .m_rec_end         (m_rec_end),
        .exp_index         (exp_index)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Present the FIFO heads from the queue models.
    task automatic applyStimulus();
        varint_empty      = (vq.size() == 0);
        varint_head_data  = '0;
        varint_head_index = '0;
        raw_empty         = (rq.size() == 0);
        raw_head_data     = '0;
        raw_head_index    = '0;
        raw_head_wstrb    = '0;
        if (vq.size() != 0) begin
            varint_head_data  = vq[0].data;
            varint_head_index = vq[0].idx;
        end
        if (rq.size() != 0) begin
            raw_head_data  = rq[0].data;
            raw_head_index = rq[0].idx;
            raw_head_wstrb = rq[0].strb;
        end
    endtask

    // One clock: sample on the falling edge, retire pops after the rising
    // edge, then re-present the heads. Returns at posedge+1.
    task automatic runCycle();
        logic  vp;
        logic  rp;
        logic  ok;
        word_t w;
        @(negedge clk);
        vp = varint_pop;
        rp = raw_pop;
        ok = !(vp && varint_empty) && !(rp && raw_empty) && !(vp && rp);
        checkOutput("pop_rules", 64'(ok), 64'd1);
        if (vp) popCount++;
        if (rp) popCount++;
        if (m_valid && m_ready) begin
            obsQ.push_back({m_src, m_index, m_data, m_wstrb});
            xferCount++;
        end
        if (m_rec_end) recEndCount++;
        @(posedge clk);
        #1;
        if (vp && vq.size() != 0) w = vq.pop_front();
        if (rp && rq.size() != 0) w = rq.pop_front();
        applyStimulus();
    endtask

    task automatic pulseClear();
        sched_clr = 1'b1;
        runCycle();
        sched_clr = 1'b0;
    endtask

    function automatic word_t mkWord(input int idx, input logic [31:0] data,
                                     input logic [3:0] strb);
        word_t w;
        w.idx  = IDX_W'(idx);
        w.data = data;
        w.strb = strb;
        return w;
    endfunction

    function automatic obs_t mkObs(input logic src, input int idx,
                                   input logic [31:0] data, input logic [3:0] strb);
        obs_t o;
        o.src  = src;
        o.idx  = IDX_W'(idx);
        o.data = data;
        o.strb = strb;
        return o;
    endfunction

    task automatic compareStream(input string tag);
        checkOutput({tag, "_count"}, 64'(obsQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput({tag, "_word"}, 64'(obsQ[i]), 64'(expQ[i]));
        end
    endtask

    initial begin
        int snapPop;
        int snapRec;
        int snapXfer;
        int lastIdx;
        int idx;
        logic [31:0] d;

        reset     = 1'b0;
        sched_clr = 1'b0;
        eos       = 1'b0;
        m_ready   = 1'b0;
        applyStimulus();

        // ---- reset state, and reset overriding a matching head ----
        repeat (3) runCycle();
        checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
        checkOutput("rst_m_data", 64'(m_data), 64'd0);
        checkOutput("rst_m_wstrb", 64'(m_wstrb), 64'd0);
        checkOutput("rst_m_index", 64'(m_index), 64'd0);
        checkOutput("rst_m_src", 64'(m_src), 64'd0);
        checkOutput("rst_rec_end", 64'(m_rec_end), 64'd0);
        checkOutput("rst_exp_index", 64'(exp_index), 64'd0);
        vq.push_back(mkWord(0, 32'h1, 4'h0));
        applyStimulus();
        snapPop = popCount;
        repeat (2) runCycle();
        checkOutput("rst_no_pop", 64'(popCount - snapPop), 64'd0);
        checkOutput("rst_hold_valid", 64'(m_valid), 64'd0);
        vq.delete();
        applyStimulus();
        reset = 1'b1;
        runCycle();

        // ---- basic ordering: varint before raw, then advance ----
        pulseClear();
        obsQ.delete();
        expQ.delete();
        vq.push_back(mkWord(0, 32'hA, 4'h0));
        vq.push_back(mkWord(0, 32'hB, 4'h0));
        vq.push_back(mkWord(1, 32'h11, 4'h0));
        rq.push_back(mkWord(0, 32'hC, 4'h3));
        rq.push_back(mkWord(1, 32'hD, 4'hF));
        expQ.push_back(mkObs(1'b0, 0, 32'hA, 4'hF));
        expQ.push_back(mkObs(1'b0, 0, 32'hB, 4'hF));
        expQ.push_back(mkObs(1'b1, 0, 32'hC, 4'h3));
        expQ.push_back(mkObs(1'b0, 1, 32'h11, 4'hF));
        expQ.push_back(mkObs(1'b1, 1, 32'hD, 4'hF));
        eos     = 1'b0;
        m_ready = 1'b1;
        applyStimulus();
        snapRec = recEndCount;
        for (int i = 0; i < 40; i++) begin
            if (obsQ.size() >= 5) break;
            runCycle();
        end
        repeat (3) runCycle();
        compareStream("basic");
        checkOutput("basic_rec_end", 64'(recEndCount - snapRec), 64'd1);
        checkOutput("basic_exp_index", 64'(exp_index), 64'd1);

        // ---- lone raw head for a later record: stall until eos ----
        pulseClear();
        obsQ.delete();
        rq.push_back(mkWord(1, 32'h77, 4'hA));
        applyStimulus();
        snapPop = popCount;
        snapRec = recEndCount;
        repeat (20) runCycle();
        checkOutput("stall_no_pop", 64'(popCount - snapPop), 64'd0);
        checkOutput("stall_no_adv", 64'(recEndCount - snapRec), 64'd0);
        checkOutput("stall_exp_index", 64'(exp_index), 64'd0);
        eos = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (obsQ.size() >= 1) break;
            runCycle();
        end
        checkOutput("eos_exp_index", 64'(exp_index), 64'd1);
        checkOutput("eos_word", 64'(obsQ[0]), 64'(mkObs(1'b1, 1, 32'h77, 4'hA)));
        eos = 1'b0;
        repeat (2) runCycle();

        // ---- backpressure ----
        pulseClear();
        obsQ.delete();
        m_ready = 1'b0;
        vq.push_back(mkWord(0, 32'h55, 4'h0));
        vq.push_back(mkWord(0, 32'h66, 4'h0));
        applyStimulus();
        runCycle();
        checkOutput("latency_valid", 64'(m_valid), 64'd1);
        snapPop = popCount;
        for (int i = 0; i < 5; i++) begin
            runCycle();
            checkOutput("bp_valid", 64'(m_valid), 64'd1);
            checkOutput("bp_data", 64'(m_data), 64'h55);
        end
        checkOutput("bp_no_pop", 64'(popCount - snapPop), 64'd0);
        snapXfer = xferCount;
        m_ready  = 1'b1;
        runCycle();
        m_ready  = 1'b0;
        checkOutput("bp_one_xfer", 64'(xferCount - snapXfer), 64'd1);
        checkOutput("bp_valid_drop", 64'(m_valid), 64'd0);
        m_ready = 1'b1;
        repeat (4) runCycle();
        checkOutput("bp_second_word", 64'(obsQ[1]), 64'(mkObs(1'b0, 0, 32'h66, 4'hF)));

        // ---- index wrap 1023 -> 0 ----
        pulseClear();
        obsQ.delete();
        expQ.delete();
        rq.push_back(mkWord(1023, 32'hDEAD_0001, 4'h5));
        rq.push_back(mkWord(0, 32'hBEEF_0002, 4'h6));
        expQ.push_back(mkObs(1'b1, 1023, 32'hDEAD_0001, 4'h5));
        expQ.push_back(mkObs(1'b1, 0, 32'hBEEF_0002, 4'h6));
        eos = 1'b1;
        applyStimulus();
        for (int i = 0; i < 2200; i++) begin
            if (exp_index == IDX_W'(1023)) break;
            runCycle();
        end
        checkOutput("wrap_reach_1023", 64'(exp_index), 64'd1023);
        for (int i = 0; i < 20; i++) begin
            if (obsQ.size() >= 2) break;
            runCycle();
        end
        compareStream("wrap");
        checkOutput("wrap_exp_index", 64'(exp_index), 64'd0);

        // ---- sched_clr while holding a word, then reset mid-stream ----
        pulseClear();
        vq.push_back(mkWord(0, 32'h0A0A, 4'h0));
        rq.push_back(mkWord(1, 32'h0B0B, 4'hF));
        rq.push_back(mkWord(1, 32'h0C0C, 4'hF));
        applyStimulus();
        for (int i = 0; i < 20; i++) begin
            if (m_valid === 1'b1 && exp_index == IDX_W'(1)) break;
            runCycle();
        end
        checkOutput("clr_reached_hold", 64'(m_valid), 64'd1);
        snapPop   = popCount;
        sched_clr = 1'b1;
        runCycle();
        sched_clr = 1'b0;
        checkOutput("clr_no_pop", 64'(popCount - snapPop), 64'd0);
        checkOutput("clr_m_valid", 64'(m_valid), 64'd0);
        checkOutput("clr_exp_index", 64'(exp_index), 64'd0);
        checkOutput("clr_m_data", 64'(m_data), 64'd0);
        checkOutput("clr_m_src", 64'(m_src), 64'd0);
        checkOutput("clr_m_index", 64'(m_index), 64'd0);
        for (int i = 0; i < 20; i++) begin
            if (m_valid === 1'b1) break;
            runCycle();
        end
        checkOutput("rst_mid_reached_hold", 64'(m_valid), 64'd1);
        reset = 1'b0;
        runCycle();
        reset = 1'b1;
        checkOutput("rst_mid_m_valid", 64'(m_valid), 64'd0);
        checkOutput("rst_mid_exp_index", 64'(exp_index), 64'd0);
        checkOutput("rst_mid_m_data", 64'(m_data), 64'd0);
        checkOutput("rst_mid_m_wstrb", 64'(m_wstrb), 64'd0);
        vq.delete();
        rq.delete();
        applyStimulus();
        eos = 1'b0;

        // ---- randomized record streams against the ordering model ----
        for (int round = 0; round < 4; round++) begin
            pulseClear();
            obsQ.delete();
            expQ.delete();
            idx     = 0;
            lastIdx = 0;
            for (int r = 0; r < int'($urandom_range(8, 16)); r++) begin
                int nv;
                int nr;
                nv = int'($urandom_range(0, 2));
                nr = int'($urandom_range(0, 2));
                for (int k = 0; k < nv; k++) begin
                    d = $urandom;
                    vq.push_back(mkWord(idx, d, 4'(($urandom))));
                    expQ.push_back(mkObs(1'b0, idx, d, 4'hF));
                    lastIdx = idx;
                end
                for (int k = 0; k < nr; k++) begin
                    logic [3:0] s;
                    d = $urandom;
                    s = 4'($urandom);
                    rq.push_back(mkWord(idx, d, s));
                    expQ.push_back(mkObs(1'b1, idx, d, s));
                    lastIdx = idx;
                end
                idx = idx + int'($urandom_range(1, 3));
            end
            eos = 1'b1;
            applyStimulus();
            snapRec = recEndCount;
            for (int i = 0; i < 1500; i++) begin
                if (vq.size() == 0 && rq.size() == 0 && m_valid === 1'b0) break;
                m_ready = ($urandom_range(0, 3) != 0);
                runCycle();
            end
            m_ready = 1'b1;
            repeat (3) runCycle();
            compareStream("rand");
            checkOutput("rand_exp_index", 64'(exp_index), 64'(lastIdx));
            checkOutput("rand_rec_ends", 64'(recEndCount - snapRec), 64'(lastIdx));
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/field_merge_sched.md
Name: field_merge_sched

Overview:
- Scheduler that drains the varint_in and raw_data_in FIFOs (filled by the AXI4 write-slave FSM) into one downstream encoder stream.
- Records are emitted in record-index order.
- Within one record index, all varint words go before all raw-data words.
- Sits between the two input FIFOs' read side and the encoder. Owns both FIFO pop strobes and a valid/ready output port.

Parameters:
- DATA_W, 32, data word width
- IDX_W, 10, record index width; wraps 2^IDX_W-1 -> 0, same as the writer's index
- STRB_W, 4, raw-data byte-strobe width
- STAT_W, 32, statistics counter width (optional feature only)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- sched_clr  in  1  synchronous clear pulse, driven with the FIFO clears
- eos  in  1  end of stream; an empty FIFO is treated as holding no more words for the current index
- varint_empty  in  1  varint FIFO empty
- varint_head_data  in  DATA_W  show-ahead head word
- varint_head_index  in  IDX_W  index tagged on the head word
- varint_pop  out  1  one-cycle pop strobe
- raw_empty  in  1  raw FIFO empty
- raw_head_data  in  DATA_W  show-ahead head word
- raw_head_index  in  IDX_W  head index
- raw_head_wstrb  in  STRB_W  head byte strobes
- raw_pop  out  1  one-cycle pop strobe
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  output word
- m_wstrb  out  STRB_W  strobes; all-ones for varint words
- m_index  out  IDX_W  record index of the word
- m_src  out  1  0 = varint, 1 = raw
- m_rec_end  out  1  one-cycle pulse when exp_index advances
- exp_index  out  IDX_W  index currently being drained

Behaviour:
- Reset (reset==0 at clk edge) and sched_clr both produce:
  - state = SCAN, exp_index = 0
  - m_valid = 0, m_data = 0, m_wstrb = 0, m_index = 0, m_src = 0
  - pops = 0, m_rec_end = 0
- If reset and sched_clr coincide, reset wins. Both override everything else in that cycle, including m_ready and pops.
- States are one-hot: SCAN, HOLD, ADV.
- Definitions: vm = !varint_empty && varint_head_index==exp_index; rm = !raw_empty && raw_head_index==exp_index.
- SCAN:
  - If vm: load output regs from the varint head (m_src=0, m_wstrb all ones), pulse varint_pop this cycle, go to HOLD.
  - Else if rm: load from the raw head (m_src=1), pulse raw_pop, go to HOLD.
  - Else if both FIFOs are non-empty (neither matches): go to ADV.
  - Else if eos and at least one FIFO is non-empty: go to ADV.
  - Else stay in SCAN (waiting for data).
- HOLD:
  - m_valid = 1; output regs stable.
  - On m_ready: m_valid drops next cycle, return to SCAN.
  - Otherwise stay in HOLD.
- ADV: exp_index <= exp_index+1 (wraps to 0 after 2^IDX_W-1), pulse m_rec_end, go to SCAN.
- Throughput: at most one word per 2 cycles. Minimum latency from head available in SCAN to m_valid=1 is 1 cycle.
- No pop is ever issued while the corresponding empty is high.
- Only one pop per transfer; varint_pop and raw_pop are never high together.
- Head index comparison is exact equality; there is no ordering or age comparison.
- Both FIFOs empty: no advance, even when eos is high. This prevents a free-running exp_index.

Optional Feature:
- Macro: FIELD_MERGE_SCHED_STATS_EN.
- With the macro:
  - Extra outputs stat_varint_words, stat_raw_words, stat_records, each STAT_W wide.
  - Counters increment on accepted varint transfers, accepted raw transfers and ADV respectively.
  - Counters saturate at all-ones.
  - Cleared by reset or sched_clr.
- Without the macro: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package field_merge_pkg holds:
  - state localparams SCAN / HOLD / ADV (one-hot)
  - SRC_VARINT = 1'b0, SRC_RAW = 1'b1
  - default widths
- Optional sub-module sched_stat_cnt: saturating counter with clr, inc and STAT_W parameter, instantiated three times under the macro. Everything else stays in one module.

Test Plan:
- Varint words idx0 0xA, 0xB plus raw idx0 0xC (wstrb 0x3); raw idx1 present; eos=0; m_ready=1:
  - outputs 0xA/src0, 0xB/src0, 0xC/src1/wstrb 0x3 in that order
  - then m_rec_end pulse and exp_index=1
- Varint FIFO empty, raw head idx1, exp_index=0, eos=0 -> no pop, no advance for 20 cycles.
- Same setup, then raise eos -> ADV, exp_index=1, raw word emitted next.
- Backpressure: m_ready=0 for 5 cycles with a word in HOLD -> m_valid stays 1, m_data stable, no further pops; m_ready=1 -> exactly one transfer.
- Wrap: force exp_index to 1023 via 1023 record advances, heads idx 0 -> exp_index wraps to 0 and the word is emitted.
- sched_clr while in HOLD with m_ready=1 -> m_valid=0 next cycle, exp_index=0, no pop; reset low mid-stream -> same values.
